seg_display_scheduler: RTL and testbench
========================================

# seg_display_scheduler

Time-multiplexed driver and source scheduler for the vending machine's 4-digit common-anode 7-segment display. Takes two packed-BCD values from the integer-to-BCD converters: the live credit and a transient notice such as change due or price. Shows credit by default and preempts it with the notice for a fixed hold time. Scans one digit at a time and decodes nibbles to segments, honouring the 4'hF blank code used for leading-zero suppression.

## Interface
- `REFRESH_DIV`, default 100000: clocks per digit slot (1 ms at 100 MHz); must be ≥2.
- `HOLD_CYCLES`, default 200000000: clocks a notice stays on screen (2 s at 100 MHz); must be ≥1.
- `clk`, in, 1: system clock; all logic on rising edge; single clock domain.
- `rst`, in, 1: synchronous, active-high reset.
- `credit_bcd`, in, 16: credit digits {d3,d2,d1,d0}, nibble 4'hF = blank; sampled live.
- `notice_bcd`, in, 16: notice digits, same encoding; sampled only on accept.
- `notice_req`, in, 1: level request to show `notice_bcd`.
- `notice_ack`, out, 1: one-cycle pulse on the cycle a request is accepted.
- `showing_notice`, out, 1: high while in NOTICE state.
- `an`, out, 4: digit enables, active-low; exactly one low after the first slot.
- `seg`, out, 7: segments {g,f,e,d,c,b,a}, active-low.

## Operation
- States: CREDIT (reset) and NOTICE.
- CREDIT, `notice_req`=1: capture `notice_bcd` into `notice_reg`, pulse `notice_ack`, load `hold_cnt`=HOLD_CYCLES-1, go to NOTICE.
- NOTICE, `notice_req`=1: recapture, pulse ack, reload `hold_cnt`; a new request always restarts the hold.
- NOTICE, no request, `hold_cnt`=0: go to CREDIT. Otherwise decrement.
- Request and expiry in the same cycle: the request wins and the block stays in NOTICE with the hold reloaded.
- Refresh counter `ref_cnt` runs 0..REFRESH_DIV-1 and wraps. On wrap, `digit_idx` advances 0→1→2→3→0.
- Frame register `frame[15:0]`: on every wrap where `digit_idx`=3 (frame boundary), load `notice_reg` if the state is NOTICE after this cycle's update, else `credit_bcd`. Source changes therefore take effect only at frame boundaries, which prevents a torn display.
- Per slot, the active nibble is `frame[4*idx+3 : 4*idx]`. `an` = ~(4'b0001 << idx), so digit 0 is rightmost.
- Decode:
  - 0–9: standard glyphs (0 → 7'b1000000, 8 → 7'b0000000).
  - 4'hF: all segments off (7'h7F).
  - 4'hA–4'hE: dash only (7'b0111111), as an error indication.
- Reset values:
  - `an`=4'hF, `seg`=7'h7F, `notice_ack`=0, `showing_notice`=0.
  - State CREDIT; `ref_cnt`, `digit_idx`, `hold_cnt` = 0.
  - `frame`=16'hFFFF and `notice_reg`=16'hFFFF.
- Reset mid-notice or mid-scan: everything returns to the reset values on the next edge, and the pending notice is discarded.

## Timing
- All outputs registered.
- `an`/`seg` update on the same edge that advances `digit_idx`, i.e. once per REFRESH_DIV clocks.
- After reset deassertion, the display stays dark until the first `ref_cnt` wrap (REFRESH_DIV cycles). Digit 1 is then selected and shows blank until the first frame load.
- `notice_ack` is high in the cycle after `notice_req` is sampled high, lasting one cycle; a held-high request re-acks every cycle.
- `showing_notice` rises together with `notice_ack`. It falls on the edge after `hold_cnt` reaches 0, giving exactly HOLD_CYCLES cycles high for a single request.
- Latency from request to glyph on the glass: at most 4·REFRESH_DIV+1 cycles (next frame boundary).

## Structure
- Shared package `display_pkg`:
  - `BLANK` = 4'hF.
  - Glyph constants `SEG_0`..`SEG_9`, `SEG_OFF`, `SEG_DASH`.
  - State enum `disp_state_t` {CREDIT, NOTICE}.
- Sub-module `seg7_decode`: combinational nibble→7-bit active-low segments; reusable by other display blocks.
- Top contains the scan counter, the hold FSM, the frame/notice registers and the output registers.

## Test plan
The bench runs with REFRESH_DIV=4 and HOLD_CYCLES=20.
- **Reset and scan:** hold rst 3 cycles with `credit_bcd`=16'hFF42.
  - `an`=4'hF and `seg`=7'h7F until the first wrap.
  - After the first frame, the `an` sequence is E,D,B,7 with `seg` = '2','4',off,off.
- **Notice preempt:** pulse `notice_req` 1 cycle with `notice_bcd`=16'hF150.
  - `notice_ack` is high exactly 1 cycle.
  - `showing_notice` is high exactly 20 cycles.
  - The next frame shows 0,5,1,off, then reverts to credit at the first frame boundary after expiry.
- **Restart:** second request 10 cycles into a notice. `showing_notice` stays high 20 cycles after the second ack, 30 total.
- **Collision:** request on the exact expiry cycle. The block stays in NOTICE with no low glitch on `showing_notice`.
- **Tear-free:** change `credit_bcd` from 16'hFF12 to 16'hFF99 while `digit_idx`=1. The current frame still completes as 2,1; the new value appears only from the next digit 0.
- **Error glyph and mid-run reset:** `credit_bcd`=16'hFFAB shows dash, dash on digits 0 and 1. Asserting rst mid-slot gives `an`=4'hF and `showing_notice`=0 on the next edge.

Source files
------------

// File: rtl/display_pkg.sv
// Shared constants for the 7-segment display blocks: blank code, active-low glyphs
// in {g,f,e,d,c,b,a} order, and the source-scheduler state type.
package display_pkg;

    localparam logic [3:0] BLANK    = 4'hF;

    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_OFF  = 7'h7F;
    localparam logic [6:0] SEG_DASH = 7'b0111111;

    typedef enum logic [0:0] {
        CREDIT = 1'b0,
        NOTICE = 1'b1
    } disp_state_t;

endpackage

// File: rtl/seg7_decode.sv
// Nibble to active-low 7-segment glyph. Blank code turns the digit off;
// non-decimal codes other than blank show a dash as an error indication.
module seg7_decode
    import display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (nibble)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            BLANK:   seg = SEG_OFF;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg_display_scheduler.sv
// 4-digit multiplexed display driver: shows live credit, preempted by a notice for a
// fixed hold time. Source changes are latched only at frame boundaries.
module seg_display_scheduler
    import display_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int HOLD_CYCLES = 200000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] credit_bcd,
    input  logic [15:0] notice_bcd,
    input  logic        notice_req,
    output logic        notice_ack,
    output logic        showing_notice,
    output logic [3:0]  an,
    output logic [6:0]  seg
);

    localparam int REF_W  = $clog2(REFRESH_DIV);
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [REF_W-1:0]  REF_LAST  = REF_W'(REFRESH_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

    disp_state_t       state, state_nxt;
    logic [15:0]       notice_reg, notice_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
    logic [REF_W-1:0]  ref_cnt;
    logic [1:0]        digit_idx, idx_nxt;
    logic [15:0]       frame, frame_nxt;
    logic              wrap;
    logic [3:0]        nibble_nxt;
    logic [6:0]        seg_dec;

    // A request always wins over expiry and restarts the hold.
    always_comb begin
        state_nxt  = state;
        notice_nxt = notice_reg;
        hold_nxt   = hold_cnt;
        if (notice_req) begin
            state_nxt  = NOTICE;
            notice_nxt = notice_bcd;
            hold_nxt   = HOLD_LOAD;
        end else if (state == NOTICE) begin
            if (hold_cnt == '0)
                state_nxt = CREDIT;
            else
                hold_nxt = hold_cnt - HOLD_W'(1);
        end
    end

    assign wrap    = (ref_cnt == REF_LAST);
    assign idx_nxt = wrap ? digit_idx + 2'd1 : digit_idx;

    always_comb begin
        frame_nxt = frame;
        if (wrap && digit_idx == 2'd3)
            frame_nxt = (state_nxt == NOTICE) ? notice_nxt : credit_bcd;
    end

    // Decode the digit about to be selected so an/seg change together.
    assign nibble_nxt = frame_nxt[{idx_nxt, 2'b00} +: 4];

    seg7_decode u_decode (
        .nibble (nibble_nxt),
        .seg    (seg_dec)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= CREDIT;
            notice_reg     <= 16'hFFFF;
            hold_cnt       <= '0;
            ref_cnt        <= '0;
            digit_idx      <= 2'd0;
            frame          <= 16'hFFFF;
            notice_ack     <= 1'b0;
            showing_notice <= 1'b0;
            an             <= 4'hF;
            seg            <= SEG_OFF;
        end else begin
            state          <= state_nxt;
            notice_reg     <= notice_nxt;
            hold_cnt       <= hold_nxt;
            notice_ack     <= notice_req;
            showing_notice <= (state_nxt == NOTICE);
            ref_cnt        <= wrap ? '0 : ref_cnt + REF_W'(1);
            digit_idx      <= idx_nxt;
            frame          <= frame_nxt;
            if (wrap) begin
                an  <= ~(4'b0001 << idx_nxt);
                seg <= seg_dec;
            end
        end
    end

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Bench for seg_display_scheduler with REFRESH_DIV=4, HOLD_CYCLES=20: scan slots are
// checked against a queue of expected {an,seg}; notice timing is measured per cycle.
module tb_seg_display_scheduler;

    localparam logic [6:0] G0   = 7'b1000000;
    localparam logic [6:0] G1   = 7'b1111001;
    localparam logic [6:0] G2   = 7'b0100100;
    localparam logic [6:0] G4   = 7'b0011001;
    localparam logic [6:0] G5   = 7'b0010010;
    localparam logic [6:0] G9   = 7'b0010000;
    localparam logic [6:0] GOFF = 7'h7F;
    localparam logic [6:0] GDSH = 7'b0111111;

    logic        clk;
    logic        rst;
    logic [15:0] credit_bcd;
    logic [15:0] notice_bcd;
    logic        notice_req;
    logic        notice_ack;
    logic        showing_notice;
    logic [3:0]  an;
    logic [6:0]  seg;

    int checks   = 0;
    int failures = 0;
    logic [10:0] sb[$];
    logic [10:0] exp_e;
    logic [3:0]  prev_an = 4'hF;
    int acks, shows;

    seg_display_scheduler #(.REFRESH_DIV(4), .HOLD_CYCLES(20)) dut (
        .clk            (clk),
        .rst            (rst),
        .credit_bcd     (credit_bcd),
        .notice_bcd     (notice_bcd),
        .notice_req     (notice_req),
        .notice_ack     (notice_ack),
        .showing_notice (showing_notice),
        .an             (an),
        .seg            (seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [3:0] a, input logic [6:0] s);
        sb.push_back({a, s});
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        check("drain", 32'(sb.size()), 32'd0);
    endtask

    task automatic wait_an(input logic [3:0] target);
        for (int i = 0; i < 100 && an !== target; i++) @(negedge clk);
        check("wait_an", 32'(an), 32'(target));
    endtask

    // Issues a request now; optionally a second one 'second_at' cycles later.
    task automatic notice_run(input int second_at, output int n_ack, output int n_show);
        bit seen;
        n_ack  = 0;
        n_show = 0;
        seen   = 1'b0;
        notice_req = 1'b1;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (notice_ack) n_ack++;
            if (showing_notice) begin
                n_show++;
                seen = 1'b1;
            end else if (seen) begin
                break;
            end
            notice_req = (c == second_at);
        end
        notice_req = 1'b0;
    endtask

    // Each new digit selection is compared against the next queued expectation.
    always @(posedge clk) begin
        #1;
        if (an !== prev_an) begin
            prev_an = an;
            if (sb.size() > 0) begin
                exp_e = sb.pop_front();
                check("scan_an", 32'(an), 32'(exp_e[10:7]));
                check("scan_seg", 32'(seg), 32'(exp_e[6:0]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        credit_bcd = 16'hFF42;
        notice_bcd = 16'h0000;
        notice_req = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("rst_an", 32'(an), 32'hF);
            check("rst_seg", 32'(seg), 32'h7F);
        end
        check("rst_ack", 32'(notice_ack), 32'd0);
        check("rst_show", 32'(showing_notice), 32'd0);

        rst = 1'b0;
        push(4'hD, GOFF); push(4'hB, GOFF); push(4'h7, GOFF);
        push(4'hE, G2);   push(4'hD, G4);   push(4'hB, GOFF); push(4'h7, GOFF);
        repeat (3) begin
            @(negedge clk);
            check("dark_an", 32'(an), 32'hF);
            check("dark_seg", 32'(seg), 32'h7F);
        end
        drain();

        // Notice preempts credit at the next frame boundary, then reverts.
        wait_an(4'h7);
        notice_bcd = 16'hF150;
        push(4'hE, G0); push(4'hD, G5); push(4'hB, G1); push(4'h7, GOFF);
        notice_run(0, acks, shows);
        check("single_ack", 32'(acks), 32'd1);
        check("single_show", 32'(shows), 32'd20);
        drain();
        wait_an(4'h7);
        push(4'hE, G2); push(4'hD, G4); push(4'hB, GOFF); push(4'h7, GOFF);
        drain();

        notice_run(10, acks, shows);
        check("restart_ack", 32'(acks), 32'd2);
        check("restart_show", 32'(shows), 32'd30);

        notice_run(20, acks, shows);
        check("collide_ack", 32'(acks), 32'd2);
        check("collide_show", 32'(shows), 32'd40);

        // Credit changes mid-frame must not tear the frame being scanned.
        credit_bcd = 16'hFF12;
        wait_an(4'h7);
        push(4'hE, G2); push(4'hD, G1);
        wait_an(4'hD);
        credit_bcd = 16'hFF99;
        push(4'hB, GOFF); push(4'h7, GOFF); push(4'hE, G9); push(4'hD, G9);
        drain();

        credit_bcd = 16'hFFAB;
        wait_an(4'h7);
        push(4'hE, GDSH); push(4'hD, GDSH);
        drain();

        // Reset during a notice discards it and darkens the display at once.
        notice_bcd = 16'h1234;
        notice_req = 1'b1;
        @(negedge clk);
        notice_req = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_rst_show", 32'(showing_notice), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_an", 32'(an), 32'hF);
        check("midrst_seg", 32'(seg), 32'h7F);
        check("midrst_show", 32'(showing_notice), 32'd0);
        check("midrst_ack", 32'(notice_ack), 32'd0);
        rst = 1'b0;
        push(4'hD, GOFF); push(4'hB, GOFF); push(4'h7, GOFF);
        push(4'hE, GDSH); push(4'hD, GDSH);
        drain();
        check("post_rst_show", 32'(showing_notice), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
